mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Shares one memory request port (valid/ready request; ordered, data-less write responses) between an instruction-fetch requester (I, read-only) and a data requester (D, read/write with byte mask).
- Sits between the CPU front/back end and the memory model.
- Arbitrates round-robin between I and D.
- Tracks up to OUTSTANDING in-flight reads with a tag FIFO, so each in-order read response is returned to the requester that issued it.

Parameters:
- CPU_WIDTH, 32, data word width in bits.
- WORD_ADDR_BITS, 30, word address width (CPU_ADDR_BITS minus log2 of bytes per word).
- OUTSTANDING, 2, maximum in-flight reads (1..8); sets tag FIFO depth.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req_val  in  1  I read request valid.
- i_req_rdy  out  1  I request accepted this cycle.
- i_req_addr  in  WORD_ADDR_BITS  I word address.
- i_resp_val  out  1  I read data valid (registered).
- i_resp_data  out  CPU_WIDTH  I read data (registered).
- d_req_val  in  1  D request valid.
- d_req_rdy  out  1  D request accepted this cycle.
- d_req_addr  in  WORD_ADDR_BITS  D word address.
- d_req_data  in  CPU_WIDTH  D write data.
- d_req_write  in  4  D byte write mask; 0 = read.
- d_resp_val  out  1  D read data valid (registered).
- d_resp_data  out  CPU_WIDTH  D read data (registered).
- mem_req_val  out  1  request to memory valid.
- mem_req_rdy  in  1  memory accepts request.
- mem_req_addr  out  WORD_ADDR_BITS  muxed address.
- mem_req_data  out  CPU_WIDTH  muxed write data (D's; 0 when I granted).
- mem_req_write  out  4  muxed mask (0 when I granted).
- mem_resp_val  in  1  memory read response valid (in order, reads only).
- mem_resp_data  in  CPU_WIDTH  memory read data.
- resp_err  out  1  sticky: a response arrived with no outstanding read.

Behaviour:
- Reset (async, reset_n=0):
  - tag FIFO empty, count=0.
  - last_grant=I, so D wins the first tie.
  - i_resp_val=d_resp_val=0, i_resp_data=d_resp_data=0, resp_err=0.
- Request eligibility (full = count==OUTSTANDING):
  - I eligible = i_req_val & ~full.
  - D eligible = d_req_val & ((d_req_write!=0) | ~full).
  - Writes never consume a tag and may issue while full.
- Grant (combinational, from current-cycle inputs and last_grant):
  - One eligible requester: it is granted.
  - Both eligible: the one not equal to last_grant is granted.
  - Neither eligible: mem_req_val=0.
  - mem_req_* carry the granted requester's fields.
  - mem_req_val = granted requester eligible.
- Ready:
  - i_req_rdy = grant==I & I eligible & mem_req_rdy; same form for d_req_rdy.
  - A non-granted requester sees rdy=0.
  - Requester fields must be held stable while val=1 and rdy=0.
- Handshake (mem_req_val & mem_req_rdy):
  - last_grant <= granted requester.
  - If the request is a read, push its tag (0=I, 1=D) into the FIFO.
  - last_grant does not change without a handshake.
- Response, one-cycle registered latency:
  - On mem_resp_val with count>0, pop the head tag.
  - Next cycle, tag's resp_val=1 and resp_data=mem_resp_data; the other resp_val=0.
  - Resp_val is a 1-cycle pulse.
  - Resp_data holds its last value when resp_val=0.
- Unexpected response: mem_resp_val with count==0 is dropped, no resp_val is generated, and resp_err <= 1 until reset.
- Simultaneous push and pop:
  - count unchanged; FIFO pointers both advance.
  - full/eligibility use the registered count only: no same-cycle bypass of a freed slot.
- Pointer wrap: read/write pointers are modulo OUTSTANDING. Count is separate, with range 0..OUTSTANDING.
- Reset mid-operation:
  - All tracking is discarded.
  - Responses to pre-reset reads arrive as unexpected and set resp_err; requesters must tolerate this.
- Write mask 4'b0000 from D is a read; any nonzero mask is a write.
- Requires CPU_WIDTH=32, matching the 4-bit mask.

Test Plan:
- Lone I read, addr 30'h10, mem_req_rdy=1; memory returns 32'hDEADBEEF two cycles later -> i_resp_val pulses 1 cycle after mem_resp_val with data 32'hDEADBEEF; d_resp_val stays 0.
- I and D reads both valid every cycle from reset, mem_req_rdy=1 -> grants D,I,D,I; each rdy high only on its own grant cycle; responses routed in the same alternating order.
- OUTSTANDING=2, three back-to-back I reads with no responses -> first two accepted, third sees i_req_rdy=0. D write mask 4'b0011 is still accepted while full. After one mem_resp_val, the third read is accepted the following cycle.
- mem_req_rdy=0 for 3 cycles with both valid -> no handshake, grant stays on the same requester, last_grant unchanged, no FIFO push.
- Same-cycle pop and push at count=2 (resp arrives while count=2; next-cycle request accepted) -> count stays 2; tags stay ordered; pointers wrap correctly over 10 mixed I/D reads.
- mem_resp_val with empty FIFO, then reset_n asserted mid-burst with 2 reads in flight -> resp_err=1 after the first event. After reset, resp_err=0, count=0, both resp_val=0; late responses set resp_err again.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between an I-fetch and a
// data requester, steering in-order read responses back via a small tag FIFO.
module mem_req_arbiter #(
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30,
    parameter int OUTSTANDING    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      i_req_val,
    output logic                      i_req_rdy,
    input  logic [WORD_ADDR_BITS-1:0] i_req_addr,
    output logic                      i_resp_val,
    output logic [CPU_WIDTH-1:0]      i_resp_data,

    input  logic                      d_req_val,
    output logic                      d_req_rdy,
    input  logic [WORD_ADDR_BITS-1:0] d_req_addr,
    input  logic [CPU_WIDTH-1:0]      d_req_data,
    input  logic [3:0]                d_req_write,
    output logic                      d_resp_val,
    output logic [CPU_WIDTH-1:0]      d_resp_data,

    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
    output logic [CPU_WIDTH-1:0]      mem_req_data,
    output logic [3:0]                mem_req_write,
    input  logic                      mem_resp_val,
    input  logic [CPU_WIDTH-1:0]      mem_resp_data,

    output logic                      resp_err
);

    localparam int   CW    = $clog2(OUTSTANDING + 1);
    localparam int   PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic TAG_I = 1'b0;
    localparam logic TAG_D = 1'b1;

    logic [CW-1:0]          count;
    logic [PW-1:0]          wptr, rptr;
    logic [OUTSTANDING-1:0] tags;
    logic                   last_grant;

    logic full, d_is_write, i_elig, d_elig, grant_d;
    logic hs, push, pop, head_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(OUTSTANDING - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Full is taken from the registered count only; a slot freed by this
    // cycle's response becomes usable next cycle.
    assign full       = (count == CW'(OUTSTANDING));
    assign d_is_write = |d_req_write;
    assign i_elig     = i_req_val & ~full;
    assign d_elig     = d_req_val & (d_is_write | ~full);

    // On a tie the requester that did not win the last handshake goes first.
    assign grant_d = d_elig & (~i_elig | (last_grant == TAG_I));

    assign mem_req_val   = grant_d ? d_elig : i_elig;
    assign mem_req_addr  = grant_d ? d_req_addr : i_req_addr;
    assign mem_req_data  = grant_d ? d_req_data : '0;
    assign mem_req_write = grant_d ? d_req_write : 4'b0000;

    assign i_req_rdy = ~grant_d & i_elig & mem_req_rdy;
    assign d_req_rdy =  grant_d & d_elig & mem_req_rdy;

    assign hs       = mem_req_val & mem_req_rdy;
    assign push     = hs & ~(grant_d & d_is_write);
    assign pop      = mem_resp_val & (count != '0);
    assign head_tag = tags[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            tags       <= '0;
            last_grant <= TAG_I;
        end else begin
            if (hs)
                last_grant <= grant_d ? TAG_D : TAG_I;
            if (push) begin
                tags[wptr] <= grant_d ? TAG_D : TAG_I;
                wptr       <= ptr_inc(wptr);
            end
            if (pop)
                rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Response steering: one registered cycle after the memory response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_resp_val  <= 1'b0;
            d_resp_val  <= 1'b0;
            i_resp_data <= '0;
            d_resp_data <= '0;
            resp_err    <= 1'b0;
        end else begin
            i_resp_val <= pop & (head_tag == TAG_I);
            d_resp_val <= pop & (head_tag == TAG_D);
            if (pop && head_tag == TAG_I)
                i_resp_data <= mem_resp_data;
            if (pop && head_tag == TAG_D)
                d_resp_data <= mem_resp_data;
            if (mem_resp_val && count == '0)
                resp_err <= 1'b1;
        end
    end

endmodule
